pc_gen: RTL and testbench
=========================

# pc_gen

Fetch-stage PC generator. It sits directly upstream of the two-level branch predictor and owns the `pcF` register that indexes the predictor's history table. It consumes the D-stage prediction/jump redirect, the M-stage mispredict correction and the exception/ERET redirect. Redirects that arrive while fetch cannot advance are buffered, and the block drives the instruction-SRAM request handshake.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, PC loaded by reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `stallF`  in  1  hazard unit holds fetch.
- `inst_req`  out  1  instruction fetch request.
- `inst_addr`  out  32  fetch address, equal to `pcF`.
- `inst_addr_ok`  in  1  SRAM accepted the request this cycle.
- `pcF`  out  32  current fetch PC, also the predictor index source.
- `pc_plus4F`  out  32  `pcF + 4`, wrapping modulo 2^32.
- `stallD`  in  1  D stage held.
- `pred_takeD`  in  1  predictor says the D-stage branch is taken.
- `branch_targetD`  in  32  branch target computed in D.
- `jumpD`  in  1  J/JAL/JR/JALR in D.
- `jump_targetD`  in  32  jump target.
- `mispredM`  in  1  M-stage branch resolution disagrees with the prediction.
- `pc_correctM`  in  32  correct continuation PC.
- `flush_excM`  in  1  exception or ERET redirect.
- `pc_excM`  in  32  handler/EPC address.
- `redirect_pendingF`  out  1  a buffered redirect is waiting.
- `adelF`  out  1  fetch address error (see Configuration).

## Operation
- `advance = inst_req & inst_addr_ok & ~stallF`. `pcF` changes only on advance, so `inst_addr` is stable while a request is outstanding.
- `inst_req = ~stallF & ~adelF`. It is 0 during reset.
- Redirect sources, highest priority first:
  - exception (`flush_excM`);
  - mispredict (`mispredM`);
  - buffered pending redirect;
  - D-stage redirect (`(pred_takeD | jumpD) & ~stallD`). Jump target wins if both are set.
  - If none applies, sequential `pc_plus4F`.
- D-stage redirect is ignored in any cycle where `flush_excM` or `mispredM` is high.
- Delay slot: when a D redirect is sampled, `pcF` already holds the delay-slot address. The target is used only as the PC *after* the delay slot is accepted; the delay-slot fetch itself is never skipped.
- On advance: `pcF` takes the winning next-PC and `pending_valid` clears.
- A redirect arriving without advance is written to `pending_pc`/`pending_valid`. A new higher- or equal-priority redirect (M-stage or exception) overwrites the buffer. A D redirect never overwrites an M-stage or exception entry.
- Exception and mispredict in the same cycle: exception wins and no mispredict state is kept.
- Redirect during reset is discarded.
- `redirect_pendingF = pending_valid`.

## Timing
- Reset (asynchronous, immediate):
  - `pcF = RESET_PC`, `pc_plus4F = RESET_PC+4`;
  - `pending_valid = 0`, `pending_pc = 0`;
  - `adelF = 0`, `inst_req = 0`, `redirect_pendingF = 0`.
- First request in the first cycle after `resetn` rises, with `inst_addr = RESET_PC`.
- Redirect-to-fetch latency:
  - 1 cycle: a redirect in cycle N with advance in N drives `pcF = target` from N+1.
  - Otherwise the target appears the cycle after the first later advance.
- Reset asserted mid-request: the request drops immediately. The SRAM side must tolerate an abandoned request.
- `pcF` wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.

## Configuration
- `PC_GEN_ALIGN_CHECK_EN` defined:
  - `adelF` is registered high whenever the loaded `pcF[1:0] != 0`.
  - While `adelF` is high, `inst_req` is forced 0 and the exception path must redirect.
  - `adelF` clears when a word-aligned redirect loads `pcF`. This load is allowed despite `inst_req = 0`, and happens on any exception redirect.
- Undefined: `adelF` is tied 0, there is no alignment logic, and `pcF[1:0]` passes through unchanged.

## Test plan
- Reset release, `inst_addr_ok` always 1: `inst_addr` sequence BFC00000, BFC00004, BFC00008; `redirect_pendingF` = 0 throughout.
- At `pcF` = BFC00010, `pred_takeD` = 1 with `branch_targetD` = BFC00100 and `stallD` = 0 -> BFC00010 fetched (delay slot), then BFC00100.
- `mispredM` = 1, `pc_correctM` = BFC00200 while `inst_addr_ok` = 0 for 3 cycles -> `redirect_pendingF` = 1 for those cycles, `pcF` held; after first accept `pcF` = BFC00200 and pending clears.
- Same cycle `flush_excM` (`pc_excM` = BFC00380) + `mispredM` (BFC00200) + `jumpD` -> next `pcF` = BFC00380 only.
- Pending mispredict BFC00200 and a later D redirect to BFC00300 while stalled -> BFC00200 loaded; BFC00300 never appears.
- With `PC_GEN_ALIGN_CHECK_EN`: `pc_correctM` = BFC00202 -> `adelF` = 1 and `inst_req` = 0; exception redirect to BFC00380 -> `adelF` = 0 and fetch resumes. Async reset pulse mid-request -> `pcF` = BFC00000 within the same cycle.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: owns pcF, arbitrates redirects, buffers late ones, drives the I-SRAM request.
// Optional fetch alignment check enabled by defining PC_GEN_ALIGN_CHECK_EN.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallF,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  input  logic        stallD,
  input  logic        pred_takeD,
  input  logic [31:0] branch_targetD,
  input  logic        jumpD,
  input  logic [31:0] jump_targetD,
  input  logic        mispredM,
  input  logic [31:0] pc_correctM,
  input  logic        flush_excM,
  input  logic [31:0] pc_excM,
  output logic        redirect_pendingF,
  output logic        adelF
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_hi_q, pend_hi_d;

  logic        advance;
  logic        load;
  logic        m_redir;
  logic        d_redir;
  logic [31:0] m_target;
  logic [31:0] d_target;
  logic [31:0] next_pc;

  // resetn gates the request combinationally so a reset mid-request drops it at once
  assign inst_req          = resetn & ~stallF & ~adelF;
  assign advance           = inst_req & inst_addr_ok & ~stallF;
  assign inst_addr         = pc_q;
  assign pcF               = pc_q;
  assign pc_plus4F         = pc_q + 32'd4;
  assign redirect_pendingF = pend_valid_q;

  always_comb begin
    m_redir  = flush_excM | mispredM;
    m_target = flush_excM ? pc_excM : pc_correctM;
    d_redir  = (pred_takeD | jumpD) & ~stallD & ~m_redir;
    d_target = jumpD ? jump_targetD : branch_targetD;

    if (m_redir)           next_pc = m_target;
    else if (pend_valid_q) next_pc = pend_pc_q;
    else if (d_redir)      next_pc = d_target;
    else                   next_pc = pc_plus4F;
  end

`ifdef PC_GEN_ALIGN_CHECK_EN
  logic adel_q, adel_d;

  // an exception redirect must be able to escape a misaligned pcF even with no request out
  assign load   = advance | (adel_q & flush_excM);
  assign adel_d = load ? (next_pc[1:0] != 2'b00) : adel_q;
  assign adelF  = adel_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) adel_q <= 1'b0;
    else         adel_q <= adel_d;
  end
`else
  assign load  = advance;
  assign adelF = 1'b0;
`endif

  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    pend_hi_d    = pend_hi_q;
    if (load) begin
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
      pend_hi_d    = 1'b0;
    end else if (m_redir) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = m_target;
      pend_hi_d    = 1'b1;
    end else if (d_redir && !(pend_valid_q && pend_hi_q)) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = d_target;
      pend_hi_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_hi_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_hi_q    <= pend_hi_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed redirect scenarios plus random stimulus against a priority-list reference model.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef PC_GEN_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        stallF, inst_req, inst_addr_ok, stallD, pred_takeD, jumpD, mispredM, flush_excM;
  logic        redirect_pendingF, adelF;
  logic [31:0] inst_addr, pcF, pc_plus4F, branch_targetD, jump_targetD, pc_correctM, pc_excM;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_pc, m_ppc;
  logic        m_pv, m_phi, m_adel;

  pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .stallF(stallF), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .pcF(pcF), .pc_plus4F(pc_plus4F), .stallD(stallD),
    .pred_takeD(pred_takeD), .branch_targetD(branch_targetD), .jumpD(jumpD),
    .jump_targetD(jump_targetD), .mispredM(mispredM), .pc_correctM(pc_correctM),
    .flush_excM(flush_excM), .pc_excM(pc_excM), .redirect_pendingF(redirect_pendingF),
    .adelF(adelF)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ppc = 32'd0; m_pv = 1'b0; m_phi = 1'b0; m_adel = 1'b0;
  endtask

  // Next state from the redirect rules: candidates listed in priority order, first one wins.
  function automatic void model_step();
    logic [31:0] cand[$];
    logic        req, adv, dreq, ld;
    logic [31:0] dtgt;
    if (!resetn) return;
    req  = !stallF && !m_adel;
    adv  = req && inst_addr_ok;
    dreq = (pred_takeD || jumpD) && !stallD && !flush_excM && !mispredM;
    dtgt = jumpD ? jump_targetD : branch_targetD;
    if (flush_excM) cand.push_back(pc_excM);
    if (mispredM)   cand.push_back(pc_correctM);
    if (m_pv)       cand.push_back(m_ppc);
    if (dreq)       cand.push_back(dtgt);
    cand.push_back(m_pc + 32'd4);
    ld = adv || (ALIGN && m_adel && flush_excM);
    if (ld) begin
      m_pc = cand[0];
      m_pv = 1'b0; m_phi = 1'b0;
      if (ALIGN) m_adel = (cand[0] % 4) != 0;
    end else if (flush_excM || mispredM) begin
      m_pv = 1'b1; m_phi = 1'b1;
      m_ppc = flush_excM ? pc_excM : pc_correctM;
    end else if (dreq && !(m_pv && m_phi)) begin
      m_pv = 1'b1; m_phi = 1'b0; m_ppc = dtgt;
    end
  endfunction

  task automatic check_outputs();
    logic exp_req;
    exp_req = resetn && !stallF && !m_adel;
    check_eq("pcF", pcF, m_pc);
    check_eq("inst_addr", inst_addr, m_pc);
    check_eq("pc_plus4F", pc_plus4F, m_pc + 32'd4);
    check_eq("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
    check_eq("pending", {31'd0, redirect_pendingF}, {31'd0, m_pv});
    check_eq("adelF", {31'd0, adelF}, {31'd0, m_adel});
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    stallF = 0; stallD = 0; pred_takeD = 0; jumpD = 0; mispredM = 0; flush_excM = 0;
    branch_targetD = 0; jump_targetD = 0; pc_correctM = 0; pc_excM = 0;
  endtask

  initial begin
    resetn = 0;
    inst_addr_ok = 1;
    idle_inputs();
    model_reset();
    mispredM = 1; pc_correctM = 32'h1234_5678;  // must be discarded during reset
    @(negedge clk); #1;
    check_eq("rst_pcF", pcF, RST_PC);
    check_eq("rst_plus4", pc_plus4F, RST_PC + 32'd4);
    check_eq("rst_req", {31'd0, inst_req}, 32'd0);
    check_eq("rst_pend", {31'd0, redirect_pendingF}, 32'd0);
    check_eq("rst_adel", {31'd0, adelF}, 32'd0);
    @(negedge clk);
    idle_inputs();
    resetn = 1;
    #1;
    check_outputs();
    check_eq("seq0", inst_addr, 32'hBFC0_0000);
    tick(); check_eq("seq1", inst_addr, 32'hBFC0_0004);
    tick(); check_eq("seq2", inst_addr, 32'hBFC0_0008);
    tick();
    tick(); check_eq("at_10", pcF, 32'hBFC0_0010);

    // branch predicted taken in D: delay slot at 10 is fetched, then the target
    pred_takeD = 1; branch_targetD = 32'hBFC0_0100;
    check_eq("delay_slot_req", {31'd0, inst_req}, 32'd1);
    tick(); idle_inputs();
    check_eq("br_target", pcF, 32'hBFC0_0100);

    // mispredict while SRAM refuses for three cycles
    mispredM = 1; pc_correctM = 32'hBFC0_0200; inst_addr_ok = 0;
    tick(); idle_inputs();
    check_eq("mp_hold0", pcF, 32'hBFC0_0100);
    check_eq("mp_pend0", {31'd0, redirect_pendingF}, 32'd1);
    tick(); check_eq("mp_pend1", {31'd0, redirect_pendingF}, 32'd1);
    tick(); check_eq("mp_pend2", {31'd0, redirect_pendingF}, 32'd1);
    check_eq("mp_hold2", pcF, 32'hBFC0_0100);
    inst_addr_ok = 1;
    tick();
    check_eq("mp_load", pcF, 32'hBFC0_0200);
    check_eq("mp_clear", {31'd0, redirect_pendingF}, 32'd0);

    // exception, mispredict and jump together: exception only
    flush_excM = 1; pc_excM = 32'hBFC0_0380; mispredM = 1; pc_correctM = 32'hBFC0_0200;
    jumpD = 1; jump_targetD = 32'hBFC0_0500;
    tick(); idle_inputs();
    check_eq("exc_wins", pcF, 32'hBFC0_0380);
    tick(); check_eq("exc_seq", pcF, 32'hBFC0_0384);

    // buffered mispredict is not displaced by a later D redirect
    inst_addr_ok = 0; mispredM = 1; pc_correctM = 32'hBFC0_0200;
    tick(); idle_inputs();
    pred_takeD = 1; branch_targetD = 32'hBFC0_0300;
    tick(); idle_inputs();
    inst_addr_ok = 1;
    tick(); check_eq("pend_keep", pcF, 32'hBFC0_0200);
    tick(); check_eq("no_300", pcF, 32'hBFC0_0204);

    // wrap at the top of the address space
    flush_excM = 1; pc_excM = 32'hFFFF_FFFC;
    tick(); idle_inputs();
    check_eq("wrap_plus4", pc_plus4F, 32'h0000_0000);
    tick(); check_eq("wrap_pc", pcF, 32'h0000_0000);

    // random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      stallF         = ($urandom_range(0, 99) < 20);
      inst_addr_ok   = ($urandom_range(0, 99) < 70);
      stallD         = ($urandom_range(0, 99) < 20);
      pred_takeD     = ($urandom_range(0, 99) < 12);
      jumpD          = ($urandom_range(0, 99) < 8);
      mispredM       = ($urandom_range(0, 99) < 6);
      flush_excM     = ($urandom_range(0, 99) < 4);
      branch_targetD = $urandom & 32'hFFFF_FFFC;
      jump_targetD   = $urandom & 32'hFFFF_FFFC;
      pc_correctM    = $urandom & 32'hFFFF_FFFC;
      pc_excM        = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    idle_inputs();
    inst_addr_ok = 1;
    tick();

`ifdef PC_GEN_ALIGN_CHECK_EN
    mispredM = 1; pc_correctM = 32'hBFC0_0202;
    tick(); idle_inputs();
    check_eq("adel_pc", pcF, 32'hBFC0_0202);
    check_eq("adel_set", {31'd0, adelF}, 32'd1);
    check_eq("adel_noreq", {31'd0, inst_req}, 32'd0);
    tick(); check_eq("adel_hold", pcF, 32'hBFC0_0202);
    flush_excM = 1; pc_excM = 32'hBFC0_0380;
    tick(); idle_inputs();
    check_eq("adel_exc_pc", pcF, 32'hBFC0_0380);
    check_eq("adel_clear", {31'd0, adelF}, 32'd0);
    check_eq("adel_resume", {31'd0, inst_req}, 32'd1);
`endif

    // asynchronous reset in the middle of an outstanding request with a pending redirect
    inst_addr_ok = 0; mispredM = 1; pc_correctM = 32'hBFC0_0600;
    tick(); idle_inputs();
    #2 resetn = 0;
    #1;
    check_eq("arst_pcF", pcF, RST_PC);
    check_eq("arst_req", {31'd0, inst_req}, 32'd0);
    check_eq("arst_pend", {31'd0, redirect_pendingF}, 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1; inst_addr_ok = 1;
    #1 check_outputs();
    tick(); check_eq("arst_seq", pcF, RST_PC + 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
